// File: rtl/comfort_pkg.sv
// -----------------------------------------------------------------------------
// comfort_pkg
// Shared definitions for the comfort-zone controller:
//   - zone_state_e : 2-bit state encoding used by both band FSMs
//   - DEF_*        : default thresholds and timing constants
//   - cnt_w()      : width of a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package comfort_pkg;

  // LOW/HIGH are "below the band" / "above the band"; MID is inside it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_MID  = 2'd3
  } zone_state_e;

  localparam int DEF_TEMP_W         = 7;
  localparam int DEF_LUME_W         = 9;
  localparam int DEF_HEAT_ON        = 15;
  localparam int DEF_COOL_ON        = 28;
  localparam int DEF_T_HYST         = 1;
  localparam int DEF_LUX_LO         = 200;
  localparam int DEF_LUX_HI         = 250;
  localparam int DEF_L_HYST         = 5;
  localparam int DEF_VACANCY_CYCLES = 1024;
  localparam int DEF_MIN_RUN        = 16;

  // At least one bit, so a disabled counter (max 0) still has a legal width.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hyst_band_fsm.sv
// -----------------------------------------------------------------------------
// hyst_band_fsm
// Three-band classifier with hysteresis and a minimum residency in the
// LOW/HIGH bands. Drops to IDLE (all outputs 0) whenever enable is low.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high
//   sample  in   [W-1:0] unsigned sensor sample
//   enable  in   zone occupied
//   low     out  registered: state was LOW  (sample below LO)
//   mid     out  registered: state was MID  (inside the band)
//   high    out  registered: state was HIGH (sample above HI)
// -----------------------------------------------------------------------------
module hyst_band_fsm
  import comfort_pkg::*;
#(
  parameter int W       = 7,
  parameter int LO      = 15,
  parameter int HI      = 28,
  parameter int HYST    = 1,
  parameter int MIN_RUN = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sample,
  input  logic         enable,
  output logic         low,
  output logic         mid,
  output logic         high
);

  // The exit points of the two outer bands must not cross each other.
  if ((LO + HYST > HI - HYST) || (HI >= (1 << W)) || (MIN_RUN < 0)) begin : g_bad_params
    $fatal(1, "hyst_band_fsm: illegal thresholds (need LO+HYST <= HI-HYST, HI < 2**W)");
  end

  localparam int DW = cnt_w(MIN_RUN);

  localparam logic [W-1:0]  LO_ON     = W'(LO);
  localparam logic [W-1:0]  HI_ON     = W'(HI);
  localparam logic [W-1:0]  LO_OFF    = W'(LO + HYST);
  localparam logic [W-1:0]  HI_OFF    = W'(HI - HYST);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_RUN);

  zone_state_e   r_state;
  zone_state_e   w_next;
  logic [DW-1:0] r_dwell;

  logic w_below;
  logic w_above;
  logic w_dwell_ok;

  assign w_below    = (sample < LO_ON);
  assign w_above    = (sample > HI_ON);
  // Dwell saturates at DWELL_MAX, so equality is the same as ">=".
  assign w_dwell_ok = (r_dwell == DWELL_MAX);

  // NOTE: w_next gets its default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_MID: begin
          if (w_below)      w_next = ST_LOW;
          else if (w_above) w_next = ST_HIGH;
          else              w_next = ST_MID;
        end
        ST_LOW: begin
          if (w_dwell_ok && (sample >= LO_OFF))
            w_next = w_above ? ST_HIGH : ST_MID;
        end
        ST_HIGH: begin
          if (w_dwell_ok && (sample <= HI_OFF))
            w_next = w_below ? ST_LOW : ST_MID;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples the values from
  // before this edge; outputs therefore lag the state by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
      low     <= 1'b0;
      mid     <= 1'b0;
      high    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)       r_dwell <= '0;
      else if (r_dwell != DWELL_MAX) r_dwell <= r_dwell + DW'(1);
      low  <= (r_state == ST_LOW);
      mid  <= (r_state == ST_MID);
      high <= (r_state == ST_HIGH);
    end
  end

endmodule

// File: rtl/comfort_zone_ctrl.sv
// -----------------------------------------------------------------------------
// comfort_zone_ctrl
// Per-room comfort controller: occupancy timer plus two hysteresis FSMs that
// drive heater/AC and three-level lighting. All actuators are off when the
// room is vacant.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high
//   temp_sens     in   [TEMP_W-1:0] temperature sample
//   lume_sens     in   [LUME_W-1:0] luminance sample
//   motion_sens   in   motion seen this cycle
//   occupied      out  occupancy timer non-zero
//   heater        out  heater on
//   ac            out  AC on
//   bright_light  out  bright lighting
//   dim_light     out  dim lighting
//   normal_light  out  normal lighting
// -----------------------------------------------------------------------------
module comfort_zone_ctrl
  import comfort_pkg::*;
#(
  parameter int TEMP_W         = DEF_TEMP_W,
  parameter int LUME_W         = DEF_LUME_W,
  parameter int HEAT_ON        = DEF_HEAT_ON,
  parameter int COOL_ON        = DEF_COOL_ON,
  parameter int T_HYST         = DEF_T_HYST,
  parameter int LUX_LO         = DEF_LUX_LO,
  parameter int LUX_HI         = DEF_LUX_HI,
  parameter int L_HYST         = DEF_L_HYST,
  parameter int VACANCY_CYCLES = DEF_VACANCY_CYCLES,
  parameter int MIN_RUN        = DEF_MIN_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_sens,
  input  logic [LUME_W-1:0] lume_sens,
  input  logic              motion_sens,
  output logic              occupied,
  output logic              heater,
  output logic              ac,
  output logic              bright_light,
  output logic              dim_light,
  output logic              normal_light
);

  if (VACANCY_CYCLES < 1) begin : g_bad_vacancy
    $fatal(1, "comfort_zone_ctrl: VACANCY_CYCLES must be at least 1");
  end

  localparam int VW = cnt_w(VACANCY_CYCLES);

  logic [VW-1:0] r_vac_cnt;
  logic          w_temp_mid_unused;

  // Motion reloads the timer and takes priority over the countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_vac_cnt <= '0;
    else if (motion_sens)       r_vac_cnt <= VW'(VACANCY_CYCLES);
    else if (r_vac_cnt != '0)   r_vac_cnt <= r_vac_cnt - VW'(1);
  end

  assign occupied = (r_vac_cnt != '0);

  // Cold side is LOW (heater), hot side is HIGH (AC).
  hyst_band_fsm #(
    .W      (TEMP_W),
    .LO     (HEAT_ON),
    .HI     (COOL_ON),
    .HYST   (T_HYST),
    .MIN_RUN(MIN_RUN)
  ) u_temp_fsm (
    .clk   (clk),
    .reset (reset),
    .sample(temp_sens),
    .enable(occupied),
    .low   (heater),
    .mid   (w_temp_mid_unused),
    .high  (ac)
  );

  // Dark room (LOW) wants bright light; sunny room (HIGH) wants dim light.
  hyst_band_fsm #(
    .W      (LUME_W),
    .LO     (LUX_LO),
    .HI     (LUX_HI),
    .HYST   (L_HYST),
    .MIN_RUN(0)
  ) u_lume_fsm (
    .clk   (clk),
    .reset (reset),
    .sample(lume_sens),
    .enable(occupied),
    .low   (bright_light),
    .mid   (normal_light),
    .high  (dim_light)
  );

endmodule
